// File: rtl/int_adder_pkg.sv
// ---------------------------------------------------------------------------
// int_adder_pkg
// Shared types and helpers for the digit-serial dual-rail add/subtract unit.
//   state_t   : controller states IDLE / CALC / OUT / RTZ
//   DR_*      : per-bit dual-rail codes (null, logic 0, logic 1, illegal)
//   dr_norm   : turns a raw rail pair into a four-phase style code; in
//               two-phase mode the pair is first XORed with its reference
//   dr_legal  : code carries a valid data value
//   dr_value  : data value of a legal code
//   dr_encode : data bit -> dual-rail code
// ---------------------------------------------------------------------------
package int_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    OUT  = 2'd2,
    RTZ  = 2'd3
  } state_t;

  localparam logic [1:0] DR_NULL = 2'b00;
  localparam logic [1:0] DR_0    = 2'b01;
  localparam logic [1:0] DR_1    = 2'b10;
  localparam logic [1:0] DR_ILL  = 2'b11;

  // In two-phase mode a rail "fires" when it differs from its stored
  // reference, so the difference pattern decodes exactly like a four-phase code.
  function automatic logic [1:0] dr_norm(input logic [1:0] code,
                                         input logic [1:0] ref_code,
                                         input logic       tp);
    return tp ? (code ^ ref_code) : code;
  endfunction

  function automatic logic dr_legal(input logic [1:0] n);
    return (n == DR_0) || (n == DR_1);
  endfunction

  function automatic logic dr_value(input logic [1:0] n);
    return n[1];
  endfunction

  function automatic logic [1:0] dr_encode(input logic v);
    return v ? DR_1 : DR_0;
  endfunction

endpackage

// File: rtl/addsub_digit.sv
// ---------------------------------------------------------------------------
// addsub_digit
// Combinational DIGIT-bit ripple add/subtract slice. Subtraction inverts the
// B slice; the caller supplies the +1 through the carry-in.
//   i_a, i_b  : operand slices
//   i_ci      : carry into the slice
//   i_sub     : 1 = use ~i_b
//   o_s       : sum slice
//   o_c_msb   : carry into the slice MSB (only with INT_ADDSUB_SEQ_OVF_EN)
//   o_co      : carry out of the slice
// ---------------------------------------------------------------------------
module addsub_digit
  import int_adder_pkg::*;
#(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] i_a,
  input  logic [DIGIT-1:0] i_b,
  input  logic             i_ci,
  input  logic             i_sub,
  output logic [DIGIT-1:0] o_s,
`ifdef INT_ADDSUB_SEQ_OVF_EN
  output logic             o_c_msb,
`endif
  output logic             o_co
);

  logic [DIGIT:0]   w_c;
  logic [DIGIT-1:0] w_b_eff;

  always_comb begin
    w_b_eff = i_b ^ {DIGIT{i_sub}};
    w_c     = '0;
    o_s     = '0;
    w_c[0]  = i_ci;
    for (int i = 0; i < DIGIT; i++) begin
      o_s[i]   = i_a[i] ^ w_b_eff[i] ^ w_c[i];
      w_c[i+1] = (i_a[i] & w_b_eff[i]) | (w_c[i] & (i_a[i] ^ w_b_eff[i]));
    end
  end

  assign o_co = w_c[DIGIT];
`ifdef INT_ADDSUB_SEQ_OVF_EN
  assign o_c_msb = w_c[DIGIT-1];
`endif

endmodule

// File: rtl/int_addsub_seq.sv
// ---------------------------------------------------------------------------
// int_addsub_seq
// Clocked digit-serial add/subtract with dual-rail operands and an ack
// handshake, in four-phase ("FP") or two-phase ("TP") encoding. A complete
// input word is captured in IDLE, summed DIGIT bits per CALC cycle through a
// single time-multiplexed addsub_digit slice, and returned in OUT.
//
// Optional feature macro: INT_ADDSUB_SEQ_OVF_EN adds the dual-rail signed
// overflow output ovf.
//
// Ports
//   clk, rst : clock, asynchronous active-high reset
//   a, b     : [WIDTH-1:0][1:0] dual-rail operands
//   c_in     : dual-rail carry-in
//   sub      : dual-rail mode, 0 add / 1 subtract (a + ~b + c_in)
//   ack_i    : acknowledge from receiver
//   ack_o    : acknowledge to sender
//   s, c_out : dual-rail result
//   ovf      : dual-rail signed overflow (macro only)
//   busy     : controller not in IDLE
//   err      : sticky illegal-code flag
// ---------------------------------------------------------------------------
module int_addsub_seq
  import int_adder_pkg::*;
#(
  parameter string ENC      = "FP",
  parameter int    WIDTH    = 8,
  parameter int    DIGIT    = 1,
  localparam int   RAIL_NUM = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  output logic                             ack_o,
  input  logic [WIDTH-1:0][RAIL_NUM-1:0]   a,
  input  logic [WIDTH-1:0][RAIL_NUM-1:0]   b,
  input  logic [RAIL_NUM-1:0]              c_in,
  input  logic [RAIL_NUM-1:0]              sub,
  input  logic                             ack_i,
  output logic [WIDTH-1:0][RAIL_NUM-1:0]   s,
  output logic [RAIL_NUM-1:0]              c_out,
  output logic                             busy,
`ifdef INT_ADDSUB_SEQ_OVF_EN
  output logic [RAIL_NUM-1:0]              ovf,
`endif
  output logic                             err
);

  localparam int   N     = WIDTH / DIGIT;
  localparam int   CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic IS_TP = (ENC == "TP");

  if (WIDTH < 1) begin : g_bad_width
    $error("int_addsub_seq: WIDTH must be at least 1");
  end
  if ((WIDTH % DIGIT) != 0) begin : g_bad_digit
    $error("int_addsub_seq: WIDTH must be a multiple of DIGIT");
  end
  if ((ENC != "FP") && (ENC != "TP")) begin : g_bad_enc
    $error("int_addsub_seq: ENC must be \"FP\" or \"TP\"");
  end

  // Control state
  state_t                   r_state;
  logic [CNT_W-1:0]         r_cnt;
  logic [WIDTH-1:0][1:0]    r_s;
  logic [1:0]               r_cout;
  logic                     r_ack;
  logic                     r_err;
  logic [WIDTH-1:0][1:0]    r_ref_a;
  logic [WIDTH-1:0][1:0]    r_ref_b;
  logic [1:0]               r_ref_cin;
  logic [1:0]               r_ref_sub;
`ifdef INT_ADDSUB_SEQ_OVF_EN
  logic [1:0]               r_ovf;
`endif

  // Datapath state
  logic [WIDTH-1:0]         r_a;
  logic [WIDTH-1:0]         r_b;
  logic [WIDTH-1:0]         r_res;
  logic                     r_cy;
  logic                     r_sub;

  // Decode
  logic [WIDTH-1:0][1:0]    w_na;
  logic [WIDTH-1:0][1:0]    w_nb;
  logic [1:0]               w_ncin;
  logic [1:0]               w_nsub;
  logic [WIDTH-1:0]         w_a_val;
  logic [WIDTH-1:0]         w_b_val;
  logic                     w_complete;
  logic                     w_illegal;
  logic                     w_all_null;

  // Arithmetic
  logic [DIGIT-1:0]         w_dsum;
  logic                     w_dco;
  logic                     w_last;
  logic [WIDTH-1:0]         w_res_next;
  logic [WIDTH-1:0][1:0]    w_s_code;
  logic [1:0]               w_cout_code;
`ifdef INT_ADDSUB_SEQ_OVF_EN
  logic                     w_dcmsb;
  logic [1:0]               w_ovf_code;
`endif

  always_comb begin
    w_na = '0;
    w_nb = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_na[i] = dr_norm(a[i], r_ref_a[i], IS_TP);
      w_nb[i] = dr_norm(b[i], r_ref_b[i], IS_TP);
    end
    w_ncin = dr_norm(c_in, r_ref_cin, IS_TP);
    w_nsub = dr_norm(sub,  r_ref_sub, IS_TP);
  end

  always_comb begin
    w_a_val    = '0;
    w_b_val    = '0;
    w_illegal  = (w_ncin == DR_ILL) | (w_nsub == DR_ILL);
    w_complete = dr_legal(w_ncin) & dr_legal(w_nsub);
    w_all_null = (w_ncin == DR_NULL) & (w_nsub == DR_NULL);
    for (int i = 0; i < WIDTH; i++) begin
      w_a_val[i] = dr_value(w_na[i]);
      w_b_val[i] = dr_value(w_nb[i]);
      w_illegal  = w_illegal  | (w_na[i] == DR_ILL) | (w_nb[i] == DR_ILL);
      w_complete = w_complete & dr_legal(w_na[i]) & dr_legal(w_nb[i]);
      w_all_null = w_all_null & (w_na[i] == DR_NULL) & (w_nb[i] == DR_NULL);
    end
  end

  // One slice, fed from the LSB end of right-shifting operand registers.
  addsub_digit #(
    .DIGIT   (DIGIT)
  ) u_digit (
    .i_a     (r_a[DIGIT-1:0]),
    .i_b     (r_b[DIGIT-1:0]),
    .i_ci    (r_cy),
    .i_sub   (r_sub),
    .o_s     (w_dsum),
`ifdef INT_ADDSUB_SEQ_OVF_EN
    .o_c_msb (w_dcmsb),
`endif
    .o_co    (w_dco)
  );

  assign w_last = (r_cnt == CNT_W'(N - 1));

  // Result shifts right and each new slice enters at the top, so after N
  // slices the first one has reached bit 0.
  assign w_res_next = (r_res >> DIGIT) | (WIDTH'(w_dsum) << (WIDTH - DIGIT));

  always_comb begin
    w_s_code = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_s_code[i] = dr_encode(w_res_next[i]);
    end
    w_cout_code = dr_encode(w_dco);
  end

`ifdef INT_ADDSUB_SEQ_OVF_EN
  assign w_ovf_code = dr_encode(w_dcmsb ^ w_dco);
`endif

  // Datapath: capture operands in IDLE, consume one slice per CALC cycle
  always_ff @(posedge clk) begin
    if (r_state == IDLE) begin
      r_a   <= w_a_val;
      r_b   <= w_b_val;
      r_cy  <= dr_value(w_ncin);
      r_sub <= dr_value(w_nsub);
    end else if (r_state == CALC) begin
      r_a   <= r_a >> DIGIT;
      r_b   <= r_b >> DIGIT;
      r_cy  <= w_dco;
      r_res <= w_res_next;
    end
  end

  // Control: handshake, output rails, references, error flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_s       <= '0;
      r_cout    <= '0;
      r_ack     <= 1'b0;
      r_err     <= 1'b0;
      r_ref_a   <= '0;
      r_ref_b   <= '0;
      r_ref_cin <= '0;
      r_ref_sub <= '0;
`ifdef INT_ADDSUB_SEQ_OVF_EN
      r_ovf     <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_illegal) r_err <= 1'b1;
          if (w_complete) begin
            r_state <= CALC;
            r_cnt   <= '0;
            if (IS_TP) begin
              r_ref_a   <= a;
              r_ref_b   <= b;
              r_ref_cin <= c_in;
              r_ref_sub <= sub;
            end
          end
        end
        CALC: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_last) begin
            r_state <= OUT;
            if (IS_TP) begin
              // Two-phase: the rail that toggles carries the value.
              r_s    <= r_s ^ w_s_code;
              r_cout <= r_cout ^ w_cout_code;
              r_ack  <= ~r_ack;
`ifdef INT_ADDSUB_SEQ_OVF_EN
              r_ovf  <= r_ovf ^ w_ovf_code;
`endif
            end else begin
              r_s    <= w_s_code;
              r_cout <= w_cout_code;
              r_ack  <= 1'b1;
`ifdef INT_ADDSUB_SEQ_OVF_EN
              r_ovf  <= w_ovf_code;
`endif
            end
          end
        end
        OUT: begin
          if (IS_TP) begin
            if (ack_i == r_ack) r_state <= IDLE;
          end else if (ack_i) begin
            r_state <= RTZ;
            r_s     <= '0;
            r_cout  <= '0;
`ifdef INT_ADDSUB_SEQ_OVF_EN
            r_ovf   <= '0;
`endif
          end
        end
        RTZ: begin
          if (w_illegal) r_err <= 1'b1;
          if (w_all_null && !ack_i) begin
            r_ack   <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign s     = r_s;
  assign c_out = r_cout;
  assign ack_o = r_ack;
  assign busy  = (r_state != IDLE);
  assign err   = r_err;
`ifdef INT_ADDSUB_SEQ_OVF_EN
  assign ovf   = r_ovf;
`endif

endmodule
